// File: rtl/dm_access_unit.sv
// Data-memory access unit for the MIPS core.
// Serves byte/half/word loads and stores against a word-wide SRAM that has
// no byte enables: sub-word stores become read-modify-write, and loads are
// lane-extracted and sign/zero-extended. One request is handled at a time.
module dm_access_unit #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_op,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    localparam logic [1:0] OP_BYTE = 2'b01;
    localparam logic [1:0] OP_HALF = 2'b10;
    localparam logic [1:0] OP_WORD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_RWAIT = 3'd2,
        ST_WR    = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    state_t      state_r;
    logic        we_r;
    logic [1:0]  op_r;
    logic        uns_r;
    logic [1:0]  lane_r;
    logic [31:0] wdata_r;

    // Upper address bits lie outside the SRAM and are intentionally dropped.
    logic        unused_addr_s;
    assign unused_addr_s = ^req_addr[31:ADDR_W+2];

    // Request is misaligned for its size, or carries the invalid op code.
    function automatic logic req_is_err(input logic [1:0] op, input logic [1:0] lane);
        logic err;
        case (op)
            OP_BYTE: err = 1'b0;
            OP_HALF: err = lane[0];
            OP_WORD: err = (lane != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    // Select the addressed byte/half of a read word and extend it to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] op,
                                                 input logic [1:0] lane, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'd0;
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (op)
            OP_BYTE: r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            OP_HALF: r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            OP_WORD: r = word;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Overwrite the addressed byte/half of the old word, keeping other lanes.
    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [1:0] op, input logic [1:0] lane);
        logic [31:0] r;
        r = old;
        case (op)
            OP_BYTE: begin
                case (lane)
                    2'd0:    r[7:0]   = wd[7:0];
                    2'd1:    r[15:8]  = wd[7:0];
                    2'd2:    r[23:16] = wd[7:0];
                    2'd3:    r[31:24] = wd[7:0];
                    default: r = old;
                endcase
            end
            OP_HALF: begin
                if (lane[1]) r[31:16] = wd[15:0];
                else         r[15:0]  = wd[15:0];
            end
            OP_WORD: r = wd;
            default: r = old;
        endcase
        return r;
    endfunction

    // Request sequencer: captures the request and drives all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            we_r       <= 1'b0;
            op_r       <= 2'b00;
            uns_r      <= 1'b0;
            lane_r     <= 2'b00;
            wdata_r    <= 32'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_r       <= req_we;
                        op_r       <= req_op;
                        uns_r      <= req_unsigned;
                        lane_r     <= req_addr[1:0];
                        wdata_r    <= req_wdata;
                        req_ready  <= 1'b0;
                        resp_rdata <= 32'd0;
                        resp_err   <= req_is_err(req_op, req_addr[1:0]);
                        if (req_is_err(req_op, req_addr[1:0])) begin
                            resp_valid <= 1'b1;
                            state_r    <= ST_RESP;
                        end else if (req_we && (req_op == OP_WORD)) begin
                            // Full-word store needs no read of the old contents.
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_addr  <= req_addr[ADDR_W+1:2];
                            mem_wdata <= req_wdata;
                            state_r   <= ST_WR;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= req_addr[ADDR_W+1:2];
                            state_r  <= ST_RD;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RD: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state_r <= ST_RWAIT;
                    end else begin
                        state_r <= ST_RD;
                    end
                end
                ST_RWAIT: begin
                    if (mem_rvalid) begin
                        if (we_r) begin
                            mem_wdata <= store_merge(mem_rdata, wdata_r, op_r, lane_r);
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            state_r   <= ST_WR;
                        end else begin
                            resp_rdata <= load_extract(mem_rdata, op_r, lane_r, uns_r);
                            resp_valid <= 1'b1;
                            state_r    <= ST_RESP;
                        end
                    end else begin
                        state_r <= ST_RWAIT;
                    end
                end
                ST_WR: begin
                    if (mem_gnt) begin
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        resp_valid <= 1'b1;
                        state_r    <= ST_RESP;
                    end else begin
                        state_r <= ST_WR;
                    end
                end
                ST_RESP: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    mem_req    <= 1'b0;
                    mem_we     <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_unit.sv
// Directed bench for dm_access_unit with a small cycle-stepped SRAM model.
module tb_dm_access_unit;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_op;
    logic              req_unsigned;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    logic [31:0]       mem_arr [0:1023];
    logic              gnt_en;
    int                n_reads;
    int                n_writes;
    int                resp_cnt;
    logic              memreq_seen;
    logic [ADDR_W-1:0] last_waddr;
    logic [31:0]       last_wdata;
    int                n_checks;
    int                n_pass;

    dm_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_op(req_op),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    // One clock: apply SRAM handshakes seen before the edge, then respond #1 after it.
    task automatic tick();
        logic              rd_fire;
        logic              wr_fire;
        logic [ADDR_W-1:0] a;
        logic [31:0]       wd;
        rd_fire = mem_req && !mem_we && mem_gnt;
        wr_fire = mem_req && mem_we && mem_gnt;
        a  = mem_addr;
        wd = mem_wdata;
        @(posedge clk);
        #1;
        if (wr_fire) begin
            mem_arr[a] = wd;
            n_writes++;
            last_waddr = a;
            last_wdata = wd;
        end
        mem_rvalid = rd_fire;
        if (rd_fire) begin
            n_reads++;
            mem_rdata = mem_arr[a];
        end
        mem_gnt = gnt_en;
        if (resp_valid) resp_cnt++;
        if (mem_req) memreq_seen = 1'b1;
    endtask

    // Issue one request, wait (bounded) for the response, and check the pulse width.
    task automatic do_req(input string tag, input logic we, input logic [1:0] op, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output int lat);
        int k;
        check({tag, ".ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_op = op; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        tick();
        // Request fields are don't-care after acceptance.
        req_valid = 1'b0; req_we = ~we; req_op = 2'b00; req_unsigned = ~uns;
        req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0;
        k = 0;
        while (!resp_valid && k < 50) begin
            tick();
            k++;
        end
        if (k == 50) check({tag, ".timeout"}, 32'(k), 32'd0);
        lat = k;
        rd  = resp_rdata;
        err = resp_err;
        check({tag, ".ready_in_resp"}, 32'(req_ready), 32'd0);
        tick();
        check({tag, ".resp_one_cycle"}, 32'(resp_valid), 32'd0);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] exp;
    } ld_vec_t;

    initial begin
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          r0;
        int          w0;
        ld_vec_t     ld_vec [5];

        n_checks = 0; n_pass = 0;
        n_reads = 0; n_writes = 0; resp_cnt = 0; memreq_seen = 1'b0;
        for (int i = 0; i < 1024; i++) mem_arr[i] = 32'd0;
        rst = 1'b1; gnt_en = 1'b1; mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        req_valid = 1'b0; req_we = 1'b0; req_op = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst.ready", 32'(req_ready), 32'd1);
        check("rst.resp_valid", 32'(resp_valid), 32'd0);
        check("rst.mem_req", 32'(mem_req), 32'd0);
        check("rst.mem_we", 32'(mem_we), 32'd0);
        check("rst.mem_addr", 32'(mem_addr), 32'd0);
        check("rst.mem_wdata", mem_wdata, 32'd0);
        check("rst.resp_rdata", resp_rdata, 32'd0);
        check("rst.resp_err", 32'(resp_err), 32'd0);

        // Word store then word load
        r0 = n_reads; w0 = n_writes;
        do_req("sw", 1'b1, 2'b11, 1'b0, 32'h0000_0008, 32'hDEAD_BEEF, rd, err, lat);
        check("sw.lat", 32'(lat), 32'd1);
        check("sw.reads", 32'(n_reads - r0), 32'd0);
        check("sw.writes", 32'(n_writes - w0), 32'd1);
        check("sw.addr", 32'(last_waddr), 32'd2);
        check("sw.wdata", last_wdata, 32'hDEAD_BEEF);
        check("sw.err", 32'(err), 32'd0);
        check("sw.rdata", rd, 32'd0);
        do_req("lw", 1'b0, 2'b11, 1'b1, 32'h0000_0008, 32'h0, rd, err, lat);
        check("lw.lat", 32'(lat), 32'd2);
        check("lw.rdata", rd, 32'hDEAD_BEEF);
        check("lw.err", 32'(err), 32'd0);

        // Byte store read-modify-write
        mem_arr[2] = 32'h1122_3344;
        r0 = n_reads; w0 = n_writes;
        do_req("sb", 1'b1, 2'b01, 1'b0, 32'h0000_000A, 32'hFFFF_FFA5, rd, err, lat);
        check("sb.lat", 32'(lat), 32'd3);
        check("sb.reads", 32'(n_reads - r0), 32'd1);
        check("sb.writes", 32'(n_writes - w0), 32'd1);
        check("sb.addr", 32'(last_waddr), 32'd2);
        check("sb.wdata", last_wdata, 32'h11A5_3344);

        // Half store into the upper lane
        mem_arr[3] = 32'h1122_3344;
        do_req("sh", 1'b1, 2'b10, 1'b0, 32'h0000_000E, 32'h1234_BEEF, rd, err, lat);
        check("sh.wdata", last_wdata, 32'hBEEF_3344);
        check("sh.err", 32'(err), 32'd0);

        // Load extension table
        mem_arr[0] = 32'h80FF_7F01;
        ld_vec[0] = '{2'b01, 1'b0, 32'h1, 32'h0000_007F};
        ld_vec[1] = '{2'b01, 1'b0, 32'h2, 32'hFFFF_FFFF};
        ld_vec[2] = '{2'b01, 1'b1, 32'h3, 32'h0000_0080};
        ld_vec[3] = '{2'b10, 1'b0, 32'h2, 32'hFFFF_80FF};
        ld_vec[4] = '{2'b10, 1'b1, 32'h2, 32'h0000_80FF};
        foreach (ld_vec[i]) begin
            do_req($sformatf("ld%0d", i), 1'b0, ld_vec[i].op, ld_vec[i].uns, ld_vec[i].addr,
                   32'h0, rd, err, lat);
            check($sformatf("ld%0d.rdata", i), rd, ld_vec[i].exp);
            check($sformatf("ld%0d.err", i), 32'(err), 32'd0);
        end

        // Misaligned / invalid requests
        memreq_seen = 1'b0;
        do_req("e_lh3", 1'b0, 2'b10, 1'b0, 32'h3, 32'h0, rd, err, lat);
        check("e_lh3.lat", 32'(lat), 32'd0);
        check("e_lh3.err", 32'(err), 32'd1);
        check("e_lh3.rdata", rd, 32'd0);
        do_req("e_sw6", 1'b1, 2'b11, 1'b0, 32'h6, 32'h1234_5678, rd, err, lat);
        check("e_sw6.lat", 32'(lat), 32'd0);
        check("e_sw6.err", 32'(err), 32'd1);
        do_req("e_op0", 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, rd, err, lat);
        check("e_op0.lat", 32'(lat), 32'd0);
        check("e_op0.err", 32'(err), 32'd1);
        check("e_op0.rdata", rd, 32'd0);
        check("err.no_mem_req", 32'(memreq_seen), 32'd0);

        // Grant stall during the write phase of a byte store
        mem_arr[4] = 32'd0;
        req_valid = 1'b1; req_we = 1'b1; req_op = 2'b01; req_unsigned = 1'b0;
        req_addr = 32'h0000_0011; req_wdata = 32'h0000_005A;
        tick();                       // accept
        req_valid = 1'b0;
        tick();                       // read grant
        gnt_en = 1'b0;
        tick();                       // rvalid sampled, write pending
        for (int i = 0; i < 5; i++) begin
            check("stall.mem_req", 32'(mem_req), 32'd1);
            check("stall.mem_we", 32'(mem_we), 32'd1);
            check("stall.mem_addr", 32'(mem_addr), 32'd4);
            check("stall.mem_wdata", mem_wdata, 32'h0000_5A00);
            check("stall.resp_valid", 32'(resp_valid), 32'd0);
            tick();
        end
        gnt_en = 1'b1; mem_gnt = 1'b1;
        tick();                       // write grant sampled
        check("stall.resp", 32'(resp_valid), 32'd1);
        check("stall.mem_req_off", 32'(mem_req), 32'd0);
        tick();
        check("stall.resp_end", 32'(resp_valid), 32'd0);
        check("stall.mem", mem_arr[4], 32'h0000_5A00);

        // Reset while waiting for read data
        w0 = n_writes;
        req_valid = 1'b1; req_we = 1'b1; req_op = 2'b01; req_unsigned = 1'b0;
        req_addr = 32'h0000_0000; req_wdata = 32'h0000_0077;
        tick();                       // accept
        req_valid = 1'b0;
        tick();                       // read grant, now waiting for rvalid
        mem_rvalid = 1'b0;
        resp_cnt = 0;
        rst = 1'b1;
        #2;
        check("rstmid.ready", 32'(req_ready), 32'd1);
        check("rstmid.mem_req", 32'(mem_req), 32'd0);
        tick();
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();                       // late rvalid must be ignored
        tick(); tick(); tick();
        check("rstmid.no_resp", 32'(resp_cnt), 32'd0);
        check("rstmid.no_write", 32'(n_writes - w0), 32'd0);
        check("rstmid.ready_after", 32'(req_ready), 32'd1);
        check("rstmid.mem_req_after", 32'(mem_req), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dm_access_unit.md
Name: dm_access_unit

Overview:
- Data-memory responder for the single-cycle/multi-cycle MIPS core.
- Accepts load/store requests qualified by the decoder's MemWrite and memOp encodings, and performs byte, half or word access against a word-wide SRAM that has no byte enables.
- Sub-word stores are done as read-modify-write. Loads are lane-extracted and sign/zero-extended.
- Sits between the core datapath and the data SRAM port.

Parameters:
- ADDR_W, 10, width of the SRAM word address; the byte address used is req_addr[ADDR_W+1:0].

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  core request valid
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_we  in  1  1 = store (MemWrite), 0 = load
- req_op  in  2  memOp: 01 byte, 10 half, 11 word, 00 invalid
- req_unsigned  in  1  load zero-extends (lbu/lhu); ignored for stores and word loads
- req_addr  in  32  byte address
- req_wdata  in  32  store data; byte = [7:0], half = [15:0]
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or invalid request, valid with resp_valid
- mem_req  out  1  SRAM request, held until granted
- mem_we  out  1  SRAM write
- mem_addr  out  ADDR_W  SRAM word address = req_addr[ADDR_W+1:2]
- mem_wdata  out  32  SRAM write word
- mem_gnt  in  1  SRAM accepts request this cycle
- mem_rvalid  in  1  read data valid; arrives at least 1 cycle after the read gnt
- mem_rdata  in  32  SRAM read word

Behaviour:
- Reset (async): state IDLE. req_ready=1. All other outputs 0, including resp_rdata, mem_addr and mem_wdata. Any in-flight request is dropped with no response; a late mem_rvalid after reset is ignored.
- Little-endian lanes:
  - Byte lane k = addr[1:0] occupies bits [8k+7:8k].
  - Half lane = addr[1] occupies [15:0] or [31:16].
- Acceptance: at an edge with req_valid & req_ready, all request fields are captured into registers. The inputs are don't-care afterwards.
- Error check at acceptance: op 00, half with addr[0]=1, or word with addr[1:0]≠0 goes directly to RESP with resp_err=1, resp_rdata=0. No memory access is made.
- States:
  - IDLE: req_ready=1. Accept a request and go to:
    - RESP if error;
    - WR if word store;
    - RD otherwise.
  - RD: mem_req=1, mem_we=0, mem_addr = captured word address. Go to RWAIT on an edge with mem_gnt.
  - RWAIT: mem_req=0. On an edge with mem_rvalid:
    - Load: extract the lane, extend it (sign unless req_unsigned), register into resp_rdata, go to RESP.
    - Sub-word store: merge req_wdata's low byte/half into the selected lane of mem_rdata, preserving the other lanes. Register the result into mem_wdata and go to WR.
    - mem_rvalid outside RWAIT is ignored.
  - WR: mem_req=1, mem_we=1, mem_wdata = full req_wdata (word store) or the merged word. Go to RESP on an edge with mem_gnt.
  - RESP: resp_valid=1 for exactly one cycle, req_ready=0, mem_req=0. Always go to IDLE. resp_rdata/resp_err hold until the next acceptance.
- Latency with mem_gnt held high and rvalid one cycle after gnt:
  - Load: accept edge E0, mem_req high E0–E1, rvalid sampled E2, resp_valid high E2–E3. Next accept possible at E4.
  - Word store: accept E0, write gnt E1, resp_valid E1–E2.
  - Sub-word store: accept E0, read gnt E1, rvalid E2, write gnt E3, resp_valid E3–E4.
  - Error: resp_valid E0–E1.
- Throughput: at most one outstanding request. No back-to-back acceptance; req_ready=0 in the RESP cycle.
- mem_gnt stall: mem_req, mem_we, mem_addr and mem_wdata hold stable while waiting. There is no timeout.
- Width rules:
  - Byte store merge replaces 8 bits; half store replaces 16 bits.
  - Word store never reads memory.
  - Word load returns mem_rdata unchanged, regardless of req_unsigned.

Test Plan:
- Word store then load: store addr 0x0000_0008, data 0xDEAD_BEEF, then load word at 0x8.
  - Required: mem_addr=2, no read before the write, resp_rdata=0xDEADBEEF, resp_err=0.
- Byte store RMW: SRAM word 2 = 0x1122_3344; store byte 0xA5 to addr 0x0A.
  - Required: one read of word 2, then write mem_wdata=0x11A5_3344; resp_valid at E3 with gnt always high.
- Load extension, SRAM word = 0x80FF_7F01:
  - lb addr 0x1 → 0x0000007F.
  - lb addr 0x2 → 0xFFFFFFFF.
  - lbu addr 0x3 → 0x00000080.
  - lh addr 0x2 → 0xFFFF80FF.
  - lhu addr 0x2 → 0x000080FF.
- Misalign/invalid: lh addr 0x3, sw addr 0x6, op 00.
  - Required for each: resp_valid the cycle after accept, resp_err=1, resp_rdata=0, mem_req never asserted.
- Grant stall: hold mem_gnt=0 for 5 cycles during a sub-word store write.
  - Required: mem_wdata/mem_addr stable and mem_req held; resp_valid exactly one cycle after gnt is sampled.
- Reset mid-op: assert rst in RWAIT, then pulse mem_rvalid after release.
  - Required: immediate IDLE with req_ready=1, no resp_valid, no write issued.
